// File: rtl/xalu_pkg.sv
// Shared types for the nibble-serial ALU: opcode set, slice width, sequencer states.
package xalu_pkg;

    localparam int XALU_SLICE_W = 4;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_AND   = 3'd1,
        OP_OR    = 3'd2,
        OP_XOR   = 3'd3,
        OP_PASSA = 3'd4,
        OP_PASSB = 3'd5,
        OP_SHR   = 3'd6,
        OP_SHL   = 3'd7
    } xalu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } xalu_state_e;

endpackage

// File: rtl/xalu_seq_if.sv
// Host-side bus of the nibble-serial ALU sequencer.
// XALU_SEQ_NEGZERO_EN adds the neg_zero status line.
interface xalu_seq_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [2:0]   op;
    logic         com;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         co;
    logic         zero;
    logic         equ;
`ifdef XALU_SEQ_NEGZERO_EN
    logic         neg_zero;
`endif

    modport master (
        output start, op, com, a, b, ci,
        input  busy, done, result, co, zero, equ
`ifdef XALU_SEQ_NEGZERO_EN
        , input neg_zero
`endif
    );

    modport slave (
        input  start, op, com, a, b, ci,
        output busy, done, result, co, zero, equ
`ifdef XALU_SEQ_NEGZERO_EN
        , output neg_zero
`endif
    );
endinterface

// File: rtl/xalu_slice.sv
// Combinational 4-bit ALU slice. "Left" is toward the MSB: ADD/SHL chain
// right-in/left-out, SHR chains left-in/right-out.
module xalu_slice
    import xalu_pkg::*;
(
    input  logic [XALU_SLICE_W-1:0] a,
    input  logic [XALU_SLICE_W-1:0] b,
    input  xalu_op_e                fn,
    input  logic                    com,
    input  logic                    cil,
    input  logic                    cir,
    output logic [XALU_SLICE_W-1:0] y,
    output logic                    col,
    output logic                    cor,
    output logic                    zero,
    output logic                    neg_zero,
    output logic                    equ
);
    logic [XALU_SLICE_W-1:0] f;

    always_comb begin
        f   = '0;
        col = 1'b0;
        cor = 1'b0;
        case (fn)
            OP_ADD:   {col, f} = {1'b0, a} + {1'b0, b} + {{XALU_SLICE_W{1'b0}}, cir};
            OP_AND:   f = a & b;
            OP_OR:    f = a | b;
            OP_XOR:   f = a ^ b;
            OP_PASSA: f = a;
            OP_PASSB: f = b;
            OP_SHR: begin
                f   = {cil, a[XALU_SLICE_W-1:1]};
                cor = a[0];
            end
            OP_SHL: begin
                f   = {a[XALU_SLICE_W-2:0], cir};
                col = a[XALU_SLICE_W-1];
            end
            default: f = '0;
        endcase
    end

    assign y        = com ? ~f : f;
    assign zero     = (y == '0);
    assign neg_zero = (y == '1);
    assign equ      = (a == b);
endmodule

// File: rtl/xalu_seq.sv
// Nibble-serial sequencer: runs a W-bit operation through one xalu_slice, one nibble per clock.
// XALU_SEQ_NEGZERO_EN adds the neg_zero (result all ones) flag.
module xalu_seq
    import xalu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    xalu_seq_if.slave  bus
);
    localparam int W    = XALU_SLICE_W * NIBBLES;
    localparam int SW   = XALU_SLICE_W;
    localparam int IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    xalu_state_e  state;
    xalu_op_e     op_q;
    logic         com_q;
    logic [IW-1:0] idx;
    logic [W-1:0] a_sr, b_sr, res_sr;
    logic         cy;
    logic         zacc, eacc;
    logic         busy_q, done_q, co_q, zero_q, equ_q;
    logic [W-1:0] result_q;

    logic         msb_first;
    logic [SW-1:0] na, nb, ny;
    logic         s_col, s_cor, s_zero, s_nz, s_equ;
    logic         cy_nxt;
    logic [W+SW-1:0] a_ext_l, b_ext_l, a_ext_m, b_ext_m, r_ext_l, r_ext_m;
    logic [W-1:0] a_nxt, b_nxt, res_nxt;

    // SHR walks MSB-to-LSB so the shifted-out bit can feed the next lower nibble.
    assign msb_first = (op_q == OP_SHR);
    assign na = msb_first ? a_sr[W-1 -: SW] : a_sr[SW-1:0];
    assign nb = msb_first ? b_sr[W-1 -: SW] : b_sr[SW-1:0];

    xalu_slice u_slice (
        .a(na), .b(nb), .fn(op_q), .com(com_q),
        .cil(cy), .cir(cy),
        .y(ny), .col(s_col), .cor(s_cor),
        .zero(s_zero),
`ifdef XALU_SEQ_NEGZERO_EN
        .neg_zero(s_nz),
`else
        .neg_zero(),
`endif
        .equ(s_equ)
    );

    assign a_ext_l = {{SW{1'b0}}, a_sr};
    assign b_ext_l = {{SW{1'b0}}, b_sr};
    assign r_ext_l = {ny, res_sr};
    assign a_ext_m = {a_sr, {SW{1'b0}}};
    assign b_ext_m = {b_sr, {SW{1'b0}}};
    assign r_ext_m = {res_sr, ny};

    assign a_nxt   = msb_first ? a_ext_m[W-1:0] : a_ext_l[W+SW-1:SW];
    assign b_nxt   = msb_first ? b_ext_m[W-1:0] : b_ext_l[W+SW-1:SW];
    assign res_nxt = msb_first ? r_ext_m[W-1:0] : r_ext_l[W+SW-1:SW];

    always_comb begin
        cy_nxt = 1'b0;
        case (op_q)
            OP_ADD, OP_SHL: cy_nxt = s_col;
            OP_SHR:         cy_nxt = s_cor;
            default:        cy_nxt = 1'b0;
        endcase
    end

`ifdef XALU_SEQ_NEGZERO_EN
    logic nacc, neg_zero_q;
    assign bus.neg_zero = neg_zero_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_q     <= OP_ADD;
            com_q    <= 1'b0;
            idx      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cy       <= 1'b0;
            zacc     <= 1'b1;
            eacc     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            co_q     <= 1'b0;
            zero_q   <= 1'b1;
            equ_q    <= 1'b0;
`ifdef XALU_SEQ_NEGZERO_EN
            nacc       <= 1'b1;
            neg_zero_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= xalu_op_e'(bus.op);
                        com_q  <= bus.com;
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        cy     <= bus.ci;
                        idx    <= '0;
                        zacc   <= 1'b1;
                        eacc   <= 1'b1;
`ifdef XALU_SEQ_NEGZERO_EN
                        nacc   <= 1'b1;
`endif
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_nxt;
                    b_sr   <= b_nxt;
                    res_sr <= res_nxt;
                    cy     <= cy_nxt;
                    zacc   <= zacc & s_zero;
                    eacc   <= eacc & s_equ;
`ifdef XALU_SEQ_NEGZERO_EN
                    nacc   <= nacc & s_nz;
`endif
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        result_q <= res_nxt;
                        co_q     <= cy_nxt;
                        zero_q   <= zacc & s_zero;
                        equ_q    <= eacc & s_equ;
`ifdef XALU_SEQ_NEGZERO_EN
                        neg_zero_q <= nacc & s_nz;
`endif
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.co     = co_q;
    assign bus.zero   = zero_q;
    assign bus.equ    = equ_q;
endmodule

// File: tb/tb_xalu_seq.sv
// Self-checking bench for xalu_seq (NIBBLES=4): directed plan cases plus random ops
// against a full-width arithmetic reference model.
module tb_xalu_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    xalu_seq_if #(.NIBBLES(4)) bus();
    xalu_seq #(.NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: plain 16-bit arithmetic, no nibble stepping.
    task automatic model(input int op, input bit cm, input logic [15:0] a, input logic [15:0] b,
                         input bit ci, output logic [15:0] r, output bit co);
        logic [16:0] s;
        co = 1'b0;
        r  = '0;
        case (op)
            0: begin s = a + b + ci; r = s[15:0]; co = s[16]; end
            1: r = a & b;
            2: r = a | b;
            3: r = a ^ b;
            4: r = a;
            5: r = b;
            6: begin r = (a >> 1) | (16'(ci) << 15); co = a[0]; end
            default: begin r = (a << 1) | 16'(ci); co = a[15]; end
        endcase
        if (cm) r = ~r;
    endtask

    // Called at a negedge; returns at the negedge of the done cycle with start low.
    task automatic run_op(input int op, input bit cm, input logic [15:0] a, input logic [15:0] b,
                          input bit ci, input bit mid);
        logic [15:0] er;
        bit eco;
        model(op, cm, a, b, ci, er, eco);
        bus.start = 1'b1; bus.op = op[2:0]; bus.com = cm; bus.a = a; bus.b = b; bus.ci = ci;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            check("busy_run", bus.busy, 1);
            check("done_early", bus.done, 0);
            if (mid && i == 2) begin
                bus.start = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom);
                bus.op = 3'($urandom); bus.ci = ~ci; bus.com = ~cm;
            end
            if (mid && i == 3) bus.start = 1'b0;
        end
        @(negedge clk);
        check("done", bus.done, 1);
        check("busy_done", bus.busy, 0);
        check("result", bus.result, er);
        check("co", bus.co, eco);
        check("zero", bus.zero, er == 16'h0);
        check("equ", bus.equ, a == b);
`ifdef XALU_SEQ_NEGZERO_EN
        check("neg_zero", bus.neg_zero, er == 16'hFFFF);
`endif
    endtask

    task automatic check_reset_vals();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_co", bus.co, 0);
        check("rst_zero", bus.zero, 1);
        check("rst_equ", bus.equ, 0);
`ifdef XALU_SEQ_NEGZERO_EN
        check("rst_neg_zero", bus.neg_zero, 0);
`endif
    endtask

    initial begin
        logic [15:0] held;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.com = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 0, 16'h00FF, 16'h0001, 0, 0);
        run_op(0, 0, 16'hFFFF, 16'h0001, 0, 0);
        run_op(7, 0, 16'h8001, 16'h5A5A, 1, 0);
        run_op(6, 0, 16'h8001, 16'hA5A5, 0, 0);
        run_op(3, 1, 16'h1234, 16'h1234, 0, 0);

        // Idle after completion: outputs hold, done drops.
        held = 16'hFFFF;
        repeat (2) @(negedge clk);
        check("hold_result", bus.result, held);
        check("hold_done", bus.done, 0);
        check("hold_equ", bus.equ, 1);

        // Mid-RUN start ignored, then back-to-back launch in the DONE cycle.
        run_op(0, 0, 16'h1234, 16'h1111, 1, 1);
        run_op(1, 0, 16'hF0F0, 16'h0FF0, 0, 0);

        // Reset in the third RUN cycle aborts.
        bus.start = 1'b1; bus.op = 3'd2; bus.com = 1'b0; bus.a = 16'h1357; bus.b = 16'h2468;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
        end

        // Reset and start together: reset wins.
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);

        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(0, 7)), 1'($urandom), 16'($urandom),
                   (n % 5 == 0) ? 16'h3C3C : 16'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xalu_seq.md
# xalu_seq

Nibble-serial sequencer that runs multi-nibble operations (default 16-bit) through a single 4-bit ALU slice. It accepts a start pulse with operands and opcode, steps the slice once per clock, chains the inter-nibble carry in the direction the opcode requires, and accumulates the result and status flags. It sits between the host register file and the ALU slice.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit nibbles per operand. Operand width is W = 4*NIBBLES. Legal range is 1..8.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  launch request.
- `op`  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
- `com`  in  1  complement-output mode; applied to every result nibble.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `ci`  in  1  carry/shift-in bit.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `result` and flags are valid while it is high.
- `result`  out  W  registered result.
- `co`  out  1  final carry or shift-out bit.
- `zero`  out  1  `result` is all zeros.
- `equ`  out  1  a == b over the full width.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE with `start`=1: latch `a`, `b`, `op`, `com`, `ci`; clear the nibble index; go to RUN.
  - RUN: process one nibble per cycle. After nibble NIBBLES-1, go to DONE.
  - DONE: lasts one cycle. Return to IDLE unless `start`=1, which relaunches.
- `start` in RUN is ignored. Operands are sampled only at acceptance, so input changes during RUN have no effect.
- Nibble order:
  - SHR: MSB nibble first.
  - All other opcodes: LSB nibble first.
- Carry chain:
  - ADD: the first nibble's carry-in is the latched `ci`. Each later nibble takes the previous slice's left carry-out.
  - SHL: the latched `ci` enters bit 0. Each later nibble's bit 0 receives the previous nibble's old bit 3.
  - SHR: the latched `ci` enters bit W-1. Each later nibble's bit 3 receives the previous nibble's old bit 0.
  - Other opcodes: no chain.
- `co` after completion:
  - ADD: carry out of bit W-1.
  - SHL: old `a[W-1]`.
  - SHR: old `a[0]`.
  - Other opcodes: 0.
- Flags:
  - `zero` is the AND of the per-nibble zero flags, evaluated after `com` is applied.
  - `equ` is the AND of the per-nibble A==B compares and is independent of `op` and `com`.
- All arithmetic is modulo 2^W. The B input is don't-care for SHL, SHR and PASSA.

## Timing
- `start` accepted at edge k:
  - `busy`=1 from cycle k+1 through k+NIBBLES.
  - `done`=1 and results valid in cycle k+NIBBLES+1.
  - Total latency is NIBBLES+1 clocks.
- `result`, `co`, `zero` and `equ` hold their values until the next completion. They are not cleared at the next `start`.
- Back-to-back: `start` in the DONE cycle is accepted. `busy` rises the next cycle, giving zero dead cycles.
- Reset values: `busy`=0, `done`=0, `result`=0, `co`=0, `zero`=1, `equ`=0. The FSM resets to IDLE.
- `rst` during RUN aborts the operation: no `done`, and all outputs take their reset values on the next edge.
- `rst` and `start` in the same cycle: `rst` wins.

## Configuration
- `XALU_SEQ_NEGZERO_EN` defined:
  - Adds output port `neg_zero` (out, 1): `result` is all ones.
  - It is the AND of the per-nibble negative-zero flags and is valid with `done`. It resets to 0.
- Macro undefined: the port and its logic are absent. Nothing else changes.

## Structure
- Shared package `xalu_pkg` holds:
  - the 3-bit opcode enum (ADD..SHL, values 0..7);
  - constant `XALU_SLICE_W` = 4;
  - FSM state typedef.
- Sub-module `xalu_slice`: a purely combinational 4-bit slice with the same function set. Its ports are nibble A/B, function, complement, left/right carry-in, left/right carry-out, zero, neg-zero and equal.
- `xalu_seq` instantiates exactly one `xalu_slice` and owns all sequential state: FSM, nibble index, operand/result shift registers and the carry register.

## Test plan
All scenarios use NIBBLES=4.
- ADD, a=0x00FF, b=0x0001, ci=0 -> result 0x0100, co=0, zero=0. `done` arrives exactly 5 cycles after `start`.
- ADD, a=0xFFFF, b=0x0001, ci=0 -> result 0x0000, co=1, zero=1. With `XALU_SEQ_NEGZERO_EN`, neg_zero=0.
- SHL, a=0x8001, ci=1 -> result 0x0003, co=1.
- SHR, a=0x8001, ci=0 -> result 0x4000, co=1.
- XOR, com=1, a=b=0x1234 -> result 0xFFFF, equ=1, zero=0. With the macro, neg_zero=1.
- Combined control check:
  - `start` pulsed mid-RUN -> ignored.
  - `rst` asserted in the 3rd RUN cycle -> no `done`; all outputs at reset values.
  - `start` in the DONE cycle -> second op (AND 0xF0F0 & 0x0FF0 = 0x00F0) completes 5 cycles later.
